// File: rtl/conv2d_3x3_stream_param_if.sv
// conv2d_3x3_stream_param_if: pixel stream in, convolution results out, plus per-frame weights
interface conv2d_3x3_stream_param_if #(parameter int DATA_WIDTH = 16);
    logic signed [DATA_WIDTH-1:0] Data_In;
    logic                         Valid_In;
    logic                         Ready_In;
    logic [9*DATA_WIDTH-1:0]      Kernel;
    logic signed [DATA_WIDTH-1:0] Bias;
    logic signed [DATA_WIDTH-1:0] Data_Out;
    logic                         Valid_Out;
    logic                         Frame_Done;
    modport master (output Data_In, Valid_In, Kernel, Bias, input Ready_In, Data_Out, Valid_Out, Frame_Done);
    modport slave (input Data_In, Valid_In, Kernel, Bias, output Ready_In, Data_Out, Valid_Out, Frame_Done);
endinterface

// File: rtl/conv2d_3x3_stream_param.sv
// conv2d_3x3_stream_param: streaming 3x3 convolution with stride, zero padding, fixed-point MAC and saturation
module conv2d_3x3_stream_param #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 30,
    parameter int IMG_HEIGHT = 30,
    parameter int STRIDE     = 1,
    parameter int PADDING    = 0,
    parameter int FRAC_BITS  = 8,
    parameter int RELU_EN    = 0
) (
    input logic clk,
    input logic rst,
    conv2d_3x3_stream_param_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int VW = IMG_WIDTH + PADDING;
    localparam int VH = IMG_HEIGHT + PADDING;
    localparam int XW = $clog2(VW);
    localparam int YW = $clog2(VH);
    localparam int AW = 2 * DW + 4;
    localparam int OW = (IMG_WIDTH + 2 * PADDING - 3) / STRIDE + 1;
    localparam int OH = (IMG_HEIGHT + 2 * PADDING - 3) / STRIDE + 1;
    localparam logic [XW-1:0] X_LAST  = XW'(VW - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(VH - 1);
    localparam logic [XW-1:0] X_PAD   = XW'(IMG_WIDTH);
    localparam logic [YW-1:0] Y_PAD   = YW'(IMG_HEIGHT);
    localparam logic [XW-1:0] X_FIRST = XW'(2 - PADDING);
    localparam logic [YW-1:0] Y_FIRST = YW'(2 - PADDING);
    localparam logic [XW-1:0] X_END   = XW'(2 - PADDING + (OW - 1) * STRIDE);
    localparam logic [YW-1:0] Y_END   = YW'(2 - PADDING + (OH - 1) * STRIDE);
    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    logic [XW-1:0] vc;
    logic [YW-1:0] vr;
    logic pad, adv, col_ok, qual, last;
    logic signed [DW-1:0] pix, top, mid;
    logic signed [DW-1:0] lb0 [VW];
    logic signed [DW-1:0] lb1 [VW];
    logic signed [DW-1:0] cl [3];
    logic signed [DW-1:0] cm [3];
    logic signed [DW-1:0] win [9];
    logic [9*DW-1:0] k_reg;
    logic signed [DW-1:0] b_reg, s2_bias, sat, res;
    logic s1_v, s1_last, s2_v, s2_last;
    logic signed [2*DW-1:0] prod [9];
    logic signed [AW-1:0] acc, shifted;

    // taps outside the image (previous row, previous frame, pad column) are forced to zero
    always_comb begin
        pad = PADDING != 0 && (vc == X_PAD || vr == Y_PAD);
        adv = pad || bus.Valid_In;
        col_ok = PADDING == 0 || vc != X_PAD;
        pix = pad ? '0 : bus.Data_In;
        top = (vr >= YW'(2) && col_ok) ? lb1[vc] : '0;
        mid = (vr != '0 && col_ok) ? lb0[vc] : '0;
        qual = vr >= Y_FIRST && vc >= X_FIRST && (STRIDE == 1 || (vr[0] == Y_FIRST[0] && vc[0] == X_FIRST[0]));
        last = vr == Y_END && vc == X_END;
    end

    assign bus.Ready_In = !pad;

    always_ff @(posedge clk) begin
        if (adv) begin
            win[0] <= vc >= XW'(2) ? cl[0] : '0;
            win[1] <= vc != '0 ? cm[0] : '0;
            win[2] <= top;
            win[3] <= vc >= XW'(2) ? cl[1] : '0;
            win[4] <= vc != '0 ? cm[1] : '0;
            win[5] <= mid;
            win[6] <= vc >= XW'(2) ? cl[2] : '0;
            win[7] <= vc != '0 ? cm[2] : '0;
            win[8] <= pix;
            cl <= cm;
            cm <= '{top, mid, pix};
            lb1[vc] <= lb0[vc];
            lb0[vc] <= pix;
        end
        if (bus.Valid_In && !pad && vr == '0 && vc == '0) begin
            k_reg <= bus.Kernel;
            b_reg <= bus.Bias;
        end
        for (int k = 0; k < 9; k++) prod[k] <= $signed(k_reg[k*DW +: DW]) * win[k];
        s2_bias <= b_reg;
    end

    // bias travels with its products so a new frame's latch cannot touch the previous frame's tail
    always_comb begin
        acc = AW'(s2_bias) <<< FRAC_BITS;
        for (int k = 0; k < 9; k++) acc = acc + AW'(prod[k]);
        shifted = acc >>> FRAC_BITS;
        sat = shifted > SAT_MAX ? SAT_MAX[DW-1:0] : shifted < SAT_MIN ? SAT_MIN[DW-1:0] : shifted[DW-1:0];
        res = (RELU_EN != 0 && sat[DW-1]) ? '0 : sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vr <= '0;
            vc <= '0;
            s1_v <= 1'b0;
            s1_last <= 1'b0;
            s2_v <= 1'b0;
            s2_last <= 1'b0;
            bus.Valid_Out <= 1'b0;
            bus.Frame_Done <= 1'b0;
            bus.Data_Out <= '0;
        end else begin
            if (adv) begin
                vc <= vc == X_LAST ? '0 : vc + 1'b1;
                if (vc == X_LAST) vr <= vr == Y_LAST ? '0 : vr + 1'b1;
            end
            s1_v <= adv && qual;
            s1_last <= adv && qual && last;
            s2_v <= s1_v;
            s2_last <= s1_last;
            bus.Valid_Out <= s2_v;
            bus.Frame_Done <= s2_v && s2_last;
            if (s2_v) bus.Data_Out <= res;
        end
    end
endmodule

// File: tb/tb_conv2d_3x3_stream_param.sv
// tb_conv2d_3x3_stream_param: two configurations driven with random frames and compared to a padded-convolution model
module tb_conv2d_3x3_stream_param;
    typedef struct {longint v; logic fd; int t;} obs_t;

    logic clk = 0;
    logic rst = 1;
    logic [1:0][15:0] din = '0;
    logic [1:0] vin = '0;
    logic [1:0][143:0] kern = '0;
    logic [1:0][15:0] bias_in = '0;
    logic [1:0] rdy, vout, fd;
    logic [1:0][15:0] dout;

    int total = 0, bad = 0, cyc = 0, cur = 0, lowcnt = 0;
    bit mon = 0;
    obs_t obs[$];
    longint px [8][8];
    longint k [9];
    longint bias;
    int tag [8][8];

    conv2d_3x3_stream_param_if #(.DATA_WIDTH(16)) a_if ();
    conv2d_3x3_stream_param_if #(.DATA_WIDTH(16)) b_if ();

    assign a_if.Data_In = din[0];
    assign a_if.Valid_In = vin[0];
    assign a_if.Kernel = kern[0];
    assign a_if.Bias = bias_in[0];
    assign b_if.Data_In = din[1];
    assign b_if.Valid_In = vin[1];
    assign b_if.Kernel = kern[1];
    assign b_if.Bias = bias_in[1];
    assign rdy = {b_if.Ready_In, a_if.Ready_In};
    assign vout = {b_if.Valid_Out, a_if.Valid_Out};
    assign fd = {b_if.Frame_Done, a_if.Frame_Done};
    assign dout = {b_if.Data_Out, a_if.Data_Out};

    conv2d_3x3_stream_param #(.DATA_WIDTH(16), .IMG_WIDTH(5), .IMG_HEIGHT(4), .STRIDE(1), .PADDING(1), .FRAC_BITS(4), .RELU_EN(0))
        dut_a (.clk(clk), .rst(rst), .bus(a_if));
    conv2d_3x3_stream_param #(.DATA_WIDTH(16), .IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(2), .PADDING(0), .FRAC_BITS(0), .RELU_EN(1))
        dut_b (.clk(clk), .rst(rst), .bus(b_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag_s, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag_s, got, exp);
        end
    endtask

    // config fields: 0=width 1=height 2=stride 3=padding 4=frac_bits 5=relu
    function automatic int cfg(input int id, input int f);
        int ca [6] = '{5, 4, 1, 1, 4, 0};
        int cb [6] = '{5, 5, 2, 0, 0, 1};
        return id != 0 ? cb[f] : ca[f];
    endfunction

    function automatic longint rv(input int lo, input int hi);
        return longint'(lo) + longint'($urandom_range(hi - lo));
    endfunction

    // output (i,j) is the 3x3 dot product over the zero-padded image at origin (i*s-p, j*s-p)
    function automatic longint expv(input int id, input int i, input int j);
        longint acc;
        int s, p, fr, rr, cc;
        s = cfg(id, 2);
        p = cfg(id, 3);
        fr = cfg(id, 4);
        acc = bias * (longint'(1) << fr);
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                rr = i * s + dy - p;
                cc = j * s + dx - p;
                if (rr >= 0 && rr < cfg(id, 1) && cc >= 0 && cc < cfg(id, 0)) acc += px[rr][cc] * k[dy * 3 + dx];
            end
        acc = acc >>> fr;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        if (cfg(id, 5) != 0 && acc < 0) acc = 0;
        return acc;
    endfunction

    // cycle in which virtual position (vr,vc) advanced; pad positions follow the last accepted pixel
    function automatic int adv_tag(input int id, input int vr, input int vc);
        int w, h;
        w = cfg(id, 0);
        h = cfg(id, 1);
        if (vr < h && vc < w) return tag[vr][vc];
        if (vr < h) return tag[vr][w - 1] + 1;
        return tag[h - 1][w - 1] + 2 + vc;
    endfunction

    always @(negedge clk) if (mon) begin
        if (vout[cur]) obs.push_back('{longint'($signed(dout[cur])), fd[cur], cyc});
        if (!rdy[cur]) lowcnt++;
        chk("idle_or_stray", {vout[1 - cur], fd[1 - cur], fd[cur] & ~vout[cur]}, 0);
    end

    task automatic drive_px(input int id, input longint v, input int r, input int c, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(2)) begin
            vin[id] = 0;
            @(posedge clk);
            #1;
        end
        din[id] = 16'(v);
        vin[id] = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[id] && n < 40);
        if (!rdy[id]) chk("accept_timeout", 0, 1);
        tag[r][c] = cyc;
        @(posedge clk);
        #1;
        vin[id] = 0;
    endtask

    task automatic run_frame(input int id, input bit gaps, input bit kchg);
        int w, h, s, p, oh, ow, n;
        w = cfg(id, 0);
        h = cfg(id, 1);
        s = cfg(id, 2);
        p = cfg(id, 3);
        oh = (h + 2 * p - 3) / s + 1;
        ow = (w + 2 * p - 3) / s + 1;
        n = oh * ow;
        cur = id;
        obs.delete();
        lowcnt = 0;
        for (int t = 0; t < 9; t++) kern[id][t*16 +: 16] = 16'(k[t]);
        bias_in[id] = 16'(bias);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                drive_px(id, px[r][c], r, c, gaps);
                if (kchg && r == 0 && c == 0) begin
                    for (int t = 0; t < 9; t++) kern[id][t*16 +: 16] = 16'($urandom);
                    bias_in[id] = 16'($urandom);
                end
            end
        repeat (2 * w + 12) @(posedge clk);
        #1;
        chk("out_count", obs.size(), n);
        for (int x = 0; x < n && x < obs.size(); x++) begin
            chk("data", obs[x].v, expv(id, x / ow, x % ow));
            chk("frame_done", obs[x].fd, x == n - 1);
            chk("latency", obs[x].t, adv_tag(id, (x / ow) * s + 2 - p, (x % ow) * s + 2 - p) + 3);
        end
        chk("ready_low_cycles", lowcnt, p != 0 ? h + w + 1 : 0);
    endtask

    task automatic fill(input int id, input int lo, input int hi, input int klo, input int khi);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) px[r][c] = rv(lo, hi);
        for (int t = 0; t < 9; t++) k[t] = rv(klo, khi);
        bias = rv(klo, khi);
    endtask

    task automatic fill_const(input longint pv, input longint kv);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) px[r][c] = pv;
        for (int t = 0; t < 9; t++) k[t] = kv;
        bias = 0;
    endtask

    initial begin
        longint ref_b [4] = '{54, 72, 144, 162};
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        for (int id = 0; id < 2; id++) begin
            chk("rst_ready", rdy[id], 1);
            chk("rst_vout", vout[id], 0);
            chk("rst_dout", dout[id], 0);
            chk("rst_fd", fd[id], 0);
        end
        mon = 1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) px[r][c] = r * 5 + c + 1;
        for (int t = 0; t < 9; t++) k[t] = t == 4 ? 16 : 0;
        bias = 0;
        run_frame(0, 0, 0);
        for (int x = 0; x < 20 && x < obs.size(); x++) chk("identity", obs[x].v, x + 1);
        fill_const(1, 16);
        run_frame(0, 0, 0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) px[r][c] = r * 5 + c;
        for (int t = 0; t < 9; t++) k[t] = 1;
        bias = 0;
        run_frame(1, 0, 0);
        for (int x = 0; x < 4; x++) chk("stride2_ref", x < obs.size() ? obs[x].v : -1, ref_b[x]);
        fill_const(32767, 32767);
        run_frame(0, 0, 0);
        run_frame(1, 0, 0);
        fill_const(32767, -32767);
        run_frame(0, 0, 0);
        run_frame(1, 0, 0);
        for (int it = 0; it < 3; it++)
            for (int id = 0; id < 2; id++) begin
                if (it == 0) fill(id, -200, 200, -64, 64);
                else fill(id, -32768, 32767, -32768, 32767);
                run_frame(id, 1, 1);
            end
        fill(0, -500, 500, -100, 100);
        cur = 0;
        for (int t = 0; t < 9; t++) kern[0][t*16 +: 16] = 16'(k[t]);
        for (int x = 0; x < 12; x++) drive_px(0, px[x / 5][x % 5], x / 5, x % 5, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        obs.delete();
        chk("abort_ready", rdy[0], 1);
        chk("abort_vout", vout[0], 0);
        chk("abort_dout", dout[0], 0);
        chk("abort_fd", fd[0], 0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_quiet", obs.size(), 0);
        fill(0, -500, 500, -100, 100);
        run_frame(0, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end
endmodule
